// File: rtl/text_line_plotter_if.sv
// Bundles the string request, glyph decoder and VGA plot ports
// of the text line plotter.
interface text_line_plotter_if #(
    parameter int MAX_CHARS = 8,
    parameter int CODE_W    = 6
);
    localparam int LEN_W = $clog2(MAX_CHARS + 1);

    logic                        start;
    logic [7:0]                  org_x;
    logic [7:0]                  org_y;
    logic [MAX_CHARS*CODE_W-1:0] str;
    logic [LEN_W-1:0]            len;

    logic [CODE_W-1:0]           glyph_code;
    logic [7:0]                  glyph_x;
    logic [7:0]                  glyph_y;
    logic [7:0]                  flush_x;
    logic [7:0]                  flush_y;
    logic [5:0]                  glyph_colour;
    logic                        glyph_enable;

    logic                        plot;
    logic [7:0]                  plot_x;
    logic [7:0]                  plot_y;
    logic [5:0]                  plot_colour;
    logic                        busy;
    logic                        done;

    modport master (
        input  start, org_x, org_y, str, len,
        input  glyph_colour, glyph_enable,
        output glyph_code, glyph_x, glyph_y,
        output flush_x, flush_y,
        output plot, plot_x, plot_y, plot_colour,
        output busy, done
    );

    modport slave (
        output start, org_x, org_y, str, len,
        output glyph_colour, glyph_enable,
        input  glyph_code, glyph_x, glyph_y,
        input  flush_x, flush_y,
        input  plot, plot_x, plot_y, plot_colour,
        input  busy, done
    );
endinterface

// File: rtl/text_line_plotter.sv
// Walks every pixel of every glyph cell of a latched string and
// turns enabled, on-screen decoder responses into plot writes.
module text_line_plotter #(
    parameter int MAX_CHARS = 8,
    parameter int CODE_W    = 6,
    parameter int CELL_W    = 10,
    parameter int CELL_H    = 10,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120
) (
    input  logic clk,
    input  logic reset,
    text_line_plotter_if.master bus
);
    localparam int LEN_W = $clog2(MAX_CHARS + 1);
    localparam int CW    = $clog2(CELL_W);
    localparam int RW    = $clog2(CELL_H);

    typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

    state_t state, state_nx;

    logic [7:0]                  ox, oy;
    logic [MAX_CHARS*CODE_W-1:0] str_q;
    logic [LEN_W-1:0]            len_q, len_clamp, ci;
    logic [CW-1:0]               col;
    logic [RW-1:0]               row;
    logic                        last_col, last_row, last_ci;
    logic [15:0]                 cell_x, pix_x, pix_y;
    logic                        on_screen;

    logic [CODE_W-1:0]           code_c;
    logic [7:0]                  gx_c, gy_c, fx_c, fy_c;
    logic                        busy_c;

    logic                        plot_q, done_q;
    logic [7:0]                  px_q, py_q;
    logic [5:0]                  pc_q;

    always_comb begin
        len_clamp = bus.len;
        if (bus.len > LEN_W'(MAX_CHARS))
            len_clamp = LEN_W'(MAX_CHARS);
    end

    assign last_col = (col == CW'(CELL_W - 1));
    assign last_row = (row == RW'(CELL_H - 1));
    assign last_ci  = (ci == len_q - LEN_W'(1));

    // Wide sums so that a wrapped 8-bit coordinate still reads as off-screen.
    assign cell_x    = {8'd0, ox} + 16'(ci) * 16'(CELL_W);
    assign pix_x     = cell_x + 16'(col);
    assign pix_y     = {8'd0, oy} + 16'(row);
    assign on_screen = (pix_x < 16'(SCREEN_W)) && (pix_y < 16'(SCREEN_H));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_nx = (len_clamp == '0) ? FINISH : SWEEP;
            end
            SWEEP: begin
                if (last_ci && last_row && last_col)
                    state_nx = FINISH;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        code_c = '0;
        gx_c   = '0;
        gy_c   = '0;
        fx_c   = '0;
        fy_c   = '0;
        busy_c = (state != IDLE);
        if (state == SWEEP) begin
            code_c = CODE_W'(str_q >> (int'(ci) * CODE_W));
            gx_c   = cell_x[7:0];
            gy_c   = oy;
            fx_c   = pix_x[7:0];
            fy_c   = pix_y[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ox    <= '0;
            oy    <= '0;
            str_q <= '0;
            len_q <= '0;
            ci    <= '0;
            col   <= '0;
            row   <= '0;
        end else if (state == IDLE && bus.start) begin
            ox    <= bus.org_x;
            oy    <= bus.org_y;
            str_q <= bus.str;
            len_q <= len_clamp;
            ci    <= '0;
            col   <= '0;
            row   <= '0;
        end else if (state == SWEEP) begin
            if (last_col) begin
                col <= '0;
                if (last_row) begin
                    row <= '0;
                    ci  <= ci + LEN_W'(1);
                end else begin
                    row <= row + RW'(1);
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // done is timed off the next state so it coincides with FINISH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            px_q   <= '0;
            py_q   <= '0;
            pc_q   <= '0;
        end else begin
            plot_q <= (state == SWEEP) && bus.glyph_enable && on_screen;
            done_q <= (state_nx == FINISH);
            if (state == SWEEP) begin
                px_q <= fx_c;
                py_q <= fy_c;
                pc_q <= bus.glyph_colour;
            end
        end
    end

    assign bus.glyph_code  = code_c;
    assign bus.glyph_x     = gx_c;
    assign bus.glyph_y     = gy_c;
    assign bus.flush_x     = fx_c;
    assign bus.flush_y     = fy_c;
    assign bus.busy        = busy_c;
    assign bus.plot        = plot_q;
    assign bus.plot_x      = px_q;
    assign bus.plot_y      = py_q;
    assign bus.plot_colour = pc_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_text_line_plotter.sv
// Scoreboard bench for text_line_plotter with a W-glyph decoder stub
// and an all-on decoder mode for clipping cases.
module tb_text_line_plotter;
    localparam logic [5:0] W_CODE = 6'd32;
    localparam logic [5:0] X_CODE = 6'd33;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    text_line_plotter_if bus ();

    text_line_plotter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int y;
        int col;
        int t;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int e0 = 0;
    int rel;
    bit track = 0;
    bit all_on = 0;

    int plots, done_cnt, done_t;
    int busy_cnt, busy_first, busy_last;
    int first_x, first_y, lx0, ly0, lx1, ly1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit w_pix(int c, int r);
        return (r <= 8 && (c == 2 || c == 7)) ||
               (r == 9 && (c == 3 || c == 6)) ||
               (r >= 6 && r <= 8 && (c == 4 || c == 5));
    endfunction

    logic [7:0] lc, lr;
    always_comb begin
        lc = bus.flush_x - bus.glyph_x;
        lr = bus.flush_y - bus.glyph_y;
        bus.glyph_colour = {lr[2:0], lc[2:0]};
        bus.glyph_enable = all_on ||
            (bus.glyph_code == W_CODE && w_pix(int'(lc), int'(lr)));
    end

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rel = cyc - e0;
        if (track) begin
            if (bus.busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = rel;
                busy_last = rel;
            end
            if (bus.done) begin
                done_cnt++;
                done_t = rel;
            end
        end
        if (bus.plot) begin
            plots++;
            if (plots == 1) begin
                first_x = int'(bus.plot_x);
                first_y = int'(bus.plot_y);
            end
            lx0 = lx1;
            ly0 = ly1;
            lx1 = int'(bus.plot_x);
            ly1 = int'(bus.plot_y);
            if (!track || sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL plot_extra: got (%0d,%0d) cycle %0d, expected none",
                         bus.plot_x, bus.plot_y, rel);
            end else begin
                e = sb.pop_front();
                check("plot_x", int'(bus.plot_x), e.x);
                check("plot_y", int'(bus.plot_y), e.y);
                check("plot_colour", int'(bus.plot_colour), e.col);
                check("plot_cycle", rel, e.t);
            end
        end
    end

    task automatic push_cell(int ox, int oy, int ci, bit all, int tmax);
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                int ax = ox + ci * 10 + c;
                int ay = oy + r;
                int t = ci * 100 + r * 10 + c + 2;
                if ((all || w_pix(c, r)) && ax < 160 && ay < 120 && t <= tmax)
                    sb.push_back('{ax, ay, (r % 8) * 8 + (c % 8), t});
            end
        end
    endtask

    task automatic wait_rel(int n);
        while (cyc - e0 < n) @(posedge clk);
        #1;
    endtask

    task automatic launch(int ox, int oy, logic [47:0] s, int l);
        @(negedge clk);
        bus.org_x = 8'(ox);
        bus.org_y = 8'(oy);
        bus.str   = s;
        bus.len   = 4'(l);
        bus.start = 1'b1;
        plots = 0;
        done_cnt = 0;
        done_t = -1;
        busy_cnt = 0;
        busy_first = -1;
        busy_last = -1;
        first_x = -1;
        first_y = -1;
        lx0 = -1; ly0 = -1; lx1 = -1; ly1 = -1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e0 = cyc - 1;
        track = 1'b1;
    endtask

    task automatic finish_run(string tag, int done_exp);
        wait_rel(done_exp + 3);
        track = 1'b0;
        check({tag, "_done_cycle"}, done_t, done_exp);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_busy_first"}, busy_first, 1);
        check({tag, "_busy_last"}, busy_last, done_exp);
        check({tag, "_busy_cycles"}, busy_cnt, done_exp);
        check({tag, "_sb_left"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_zero(string tag);
        check({tag, "_plot"}, int'(bus.plot), 0);
        check({tag, "_plot_x"}, int'(bus.plot_x), 0);
        check({tag, "_plot_y"}, int'(bus.plot_y), 0);
        check({tag, "_plot_colour"}, int'(bus.plot_colour), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_glyph_code"}, int'(bus.glyph_code), 0);
        check({tag, "_glyph_xy"}, int'({bus.glyph_x, bus.glyph_y}), 0);
        check({tag, "_flush_xy"}, int'({bus.flush_x, bus.flush_y}), 0);
    endtask

    logic [47:0] s;

    initial begin
        bus.start = 1'b0;
        bus.org_x = '0;
        bus.org_y = '0;
        bus.str   = '0;
        bus.len   = '0;
        plots = 0;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // single W at (20,30)
        s = '0;
        s[5:0] = W_CODE;
        push_cell(20, 30, 0, 0, 100000);
        launch(20, 30, s, 1);
        finish_run("w1", 101);
        check("w1_plots", plots, 26);
        check("w1_first_x", first_x, 22);
        check("w1_first_y", first_y, 30);
        check("w1_pen_x", lx0, 23);
        check("w1_pen_y", ly0, 39);
        check("w1_last_x", lx1, 26);
        check("w1_last_y", ly1, 39);

        // empty string
        launch(20, 30, s, 0);
        finish_run("len0", 1);
        check("len0_plots", plots, 0);

        // clipping at the bottom-right corner
        all_on = 1'b1;
        s = '0;
        s[5:0] = X_CODE;
        s[11:6] = X_CODE;
        push_cell(155, 115, 0, 1, 100000);
        push_cell(155, 115, 1, 1, 100000);
        launch(155, 115, s, 2);
        finish_run("clip", 201);
        check("clip_plots", plots, 25);

        // 8-bit x wraps past 255 and must stay off-screen
        launch(250, 0, s, 1);
        finish_run("wrap", 101);
        check("wrap_plots", plots, 0);
        all_on = 1'b0;

        // length above capacity clamps to 8 characters
        s = '0;
        launch(0, 0, s, 15);
        finish_run("clamp", 801);
        check("clamp_plots", plots, 0);

        // three characters, second start ignored mid-string
        s = '0;
        s[5:0] = W_CODE;
        s[11:6] = X_CODE;
        s[17:12] = W_CODE;
        push_cell(20, 30, 0, 0, 100000);
        push_cell(20, 30, 2, 0, 100000);
        launch(20, 30, s, 3);
        wait_rel(50);
        bus.start = 1'b1;
        bus.org_x = 8'd0;
        bus.org_y = 8'd0;
        bus.len   = 4'd1;
        wait_rel(51);
        bus.start = 1'b0;
        finish_run("len3", 301);
        check("len3_plots", plots, 52);

        // reset in cycle 40 of a two-character string
        s = '0;
        s[5:0] = W_CODE;
        s[11:6] = W_CODE;
        push_cell(20, 30, 0, 0, 39);
        launch(20, 30, s, 2);
        wait_rel(40);
        reset = 1'b1;
        @(negedge clk);
        check_zero("abort");
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_rel(260);
        track = 1'b0;
        check("abort_plots", plots, 8);
        check("abort_done", done_cnt, 0);
        check("abort_sb_left", sb.size(), 0);
        sb.delete();

        // fresh start after the abort
        s = '0;
        s[5:0] = W_CODE;
        push_cell(0, 0, 0, 0, 100000);
        launch(0, 0, s, 1);
        finish_run("fresh", 101);
        check("fresh_plots", plots, 26);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
